ifu_fetch: RTL



---
 rtl/ifu_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
// ifu_fetch: sequential-PC fetch stage with credit-limited request issue, in-order
// tag queue, instruction buffer and redirect flush.  Revision 1.0
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   input  logic        i_imem_rsp_err,
   output logic        o_id_valid,
   input  logic        i_id_ready,
   output logic [31:0] o_id_instr,
   output logic [31:0] o_id_pc,
   output logic        o_id_err
);

   localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]      pc;
   logic [31:0]      last_pc;

   logic [31:0]      tag_pc [DEPTH];
   logic [DEPTH-1:0] tag_live;
   logic [PW-1:0]    tag_wr, tag_rd;
   logic [CW-1:0]    tag_cnt;

   logic [31:0]      buf_instr [DEPTH];
   logic [31:0]      buf_pc    [DEPTH];
   logic [DEPTH-1:0] buf_err;
   logic [PW-1:0]    buf_wr, buf_rd;
   logic [CW-1:0]    buf_cnt;

   logic             credit_ok;
   logic             req_fire;
   logic             rsp_take;
   logic             rsp_keep;
   logic             id_fire;
   logic [31:0]      redirect_target;
   logic             unused_pc_bits;

   assign redirect_target = {i_redirect_pc[31:2], 2'b00};
   assign unused_pc_bits  = ^i_redirect_pc[1:0];

   // Words in flight plus words waiting for decode never exceed the buffer size,
   // so every accepted response is guaranteed a buffer slot.
   assign credit_ok        = ({1'b0, tag_cnt} + {1'b0, buf_cnt}) < (CW+1)'(DEPTH);
   assign o_imem_req_valid = ~i_rst & ~i_redirect & credit_ok;
   assign o_imem_req_addr  = pc;

   assign req_fire = o_imem_req_valid & i_imem_req_ready;
   assign rsp_take = i_imem_rsp_valid & (tag_cnt != '0);
   assign rsp_keep = rsp_take & tag_live[tag_rd] & ~i_redirect;
   assign id_fire  = o_id_valid & i_id_ready;

   assign o_id_valid = (buf_cnt != '0);
   assign o_id_instr = o_id_valid ? buf_instr[buf_rd] : NOP;
   assign o_id_pc    = o_id_valid ? buf_pc[buf_rd]    : last_pc;
   assign o_id_err   = o_id_valid & buf_err[buf_rd];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc       <= RESET_PC;
         last_pc  <= '0;
         tag_live <= '0;
         tag_wr   <= '0;
         tag_rd   <= '0;
         tag_cnt  <= '0;
         buf_wr   <= '0;
         buf_rd   <= '0;
         buf_cnt  <= '0;
      end else begin
         if (i_redirect)
            pc <= redirect_target;
         else if (req_fire)
            pc <= pc + 32'd4;

         if (req_fire) begin
            tag_wr           <= tag_wr + PW'(1);
            tag_live[tag_wr] <= 1'b1;
         end
         // Stale entries keep their slot (and credit) until their response drains.
         if (i_redirect)
            tag_live <= '0;
         if (rsp_take)
            tag_rd <= tag_rd + PW'(1);
         tag_cnt <= tag_cnt + CW'(req_fire) - CW'(rsp_take);

         if (id_fire)
            last_pc <= buf_pc[buf_rd];

         if (i_redirect) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
         end else begin
            if (rsp_keep)
               buf_wr <= buf_wr + PW'(1);
            if (id_fire)
               buf_rd <= buf_rd + PW'(1);
            buf_cnt <= buf_cnt + CW'(rsp_keep) - CW'(id_fire);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (req_fire)
         tag_pc[tag_wr] <= pc;
      if (rsp_keep) begin
         buf_instr[buf_wr] <= i_imem_rsp_err ? NOP : i_imem_rsp_data;
         buf_pc[buf_wr]    <= tag_pc[tag_rd];
         buf_err[buf_wr]   <= i_imem_rsp_err;
      end
   end

   a_rsp_has_tag : assert property (@(posedge i_clk) disable iff (i_rst)
      i_imem_rsp_valid |-> (tag_cnt != '0));

endmodule
`default_nettype wire
